// File: rtl/hazard_scoreboard_if.sv
// Issue/fetch/status bundle between the pipeline and the hazard scoreboard.
// master drives issue and fetch requests; slave returns stalls and status.
interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int LAT_W = 3
);
  logic               issue_valid;
  logic               issue_wr;
  logic [REG_W-1:0]   issue_rd;
  logic [LAT_W-1:0]   issue_lat;
  logic               issue_kill;
  logic               FETCH_valid;
  logic [REG_W-1:0]   FETCH_rs1;
  logic [REG_W-1:0]   FETCH_rs2;
  logic               FETCH_stall;
  logic               ISSUE_stall;
  logic [2**REG_W-1:0] busy_vec;
  logic [REG_W:0]     pending_cnt;

  modport master (
    output issue_valid, issue_wr, issue_rd,
    output issue_lat, issue_kill,
    output FETCH_valid, FETCH_rs1, FETCH_rs2,
    input  FETCH_stall, ISSUE_stall,
    input  busy_vec, pending_cnt
  );

  modport slave (
    input  issue_valid, issue_wr, issue_rd,
    input  issue_lat, issue_kill,
    input  FETCH_valid, FETCH_rs1, FETCH_rs2,
    output FETCH_stall, ISSUE_stall,
    output busy_vec, pending_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register result-latency scoreboard producing RAW fetch stalls
// and WAW issue stalls; x0 is never tracked.
module hazard_scoreboard #(
  parameter int REG_W   = 5,
  parameter int LAT_W   = 3,
  parameter int MAX_LAT = 6
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int NREG = 2**REG_W;
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] TWO   = LAT_W'(2);

  logic [LAT_W-1:0]  cnt     [NREG];
  logic [LAT_W-1:0]  cnt_nxt [NREG];
  logic [NREG-1:0]   busy_nxt;
  logic [REG_W:0]    pend_nxt;
  logic [LAT_W-1:0]  eff_lat;
  logic              wr_req;
  logic              issue_stall;
  logic              accept;
  logic              haz1;
  logic              haz2;

  assign eff_lat = (bus.issue_lat > MAX_L) ? MAX_L
                                           : bus.issue_lat;

  assign wr_req = bus.issue_valid & bus.issue_wr
                & ~bus.issue_kill
                & (bus.issue_rd != '0);

  // An older, longer-latency write must finish first.
  assign issue_stall = wr_req & ~rst
                     & (cnt[bus.issue_rd] > eff_lat);

  assign accept = wr_req & (eff_lat != '0) & ~issue_stall;

  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    if (bus.FETCH_rs1 != '0 && cnt[bus.FETCH_rs1] >= TWO)
      haz1 = 1'b1;
    if (accept && bus.issue_rd == bus.FETCH_rs1
        && eff_lat >= TWO)
      haz1 = 1'b1;
    if (bus.FETCH_rs2 != '0 && cnt[bus.FETCH_rs2] >= TWO)
      haz2 = 1'b1;
    if (accept && bus.issue_rd == bus.FETCH_rs2
        && eff_lat >= TWO)
      haz2 = 1'b1;
  end

  assign bus.FETCH_stall = bus.FETCH_valid & ~rst
                         & (haz1 | haz2);
  assign bus.ISSUE_stall = issue_stall;

  always_comb begin
    busy_nxt = '0;
    pend_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
      if (accept && bus.issue_rd == REG_W'(r))
        cnt_nxt[r] = eff_lat;
      if (r == 0)
        cnt_nxt[r] = '0;
      busy_nxt[r] = (cnt_nxt[r] != '0);
      pend_nxt = pend_nxt + (REG_W+1)'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      bus.busy_vec    <= '0;
      bus.pending_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_nxt[r];
      bus.busy_vec    <= busy_nxt;
      bus.pending_cnt <= pend_nxt;
    end
  end
endmodule
